// File: rtl/uart_bus_master.sv
// UART-driven debug bus initiator: decodes W/R command frames from the byte receiver and runs single-word bus cycles.
// Optional inter-byte abort timer is enabled by defining UART_BUS_MASTER_TIMEOUT_EN.
module uart_bus_master #(
  parameter int unsigned TIMEOUT_CYCLES = 1250000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_ready,
  output logic        rx_ack,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_ready,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_BUS,
    S_RESP
  } state_t;

  state_t      state, state_n;
  logic [1:0]  cnt;
  logic        is_write;
  logic [31:2] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] resp_q;
  logic        resp_one;
  logic        rx_ack_q;
  logic        tx_start_q;
  logic [7:0]  tx_hold;
  logic [7:0]  tx_byte;
  logic        rx_state;

  assign rx_state = (state == S_IDLE) || (state == S_ADDR) || (state == S_DATA);
  assign tx_byte  = resp_q[{cnt, 3'b000} +: 8];

`ifdef UART_BUS_MASTER_TIMEOUT_EN
  localparam logic [20:0] TIMEOUT_LIMIT = 21'(TIMEOUT_CYCLES);
  logic [20:0] idle_cnt;
  logic        timeout;

  assign timeout = ((state == S_ADDR) || (state == S_DATA)) && !rx_ack &&
                   (idle_cnt == TIMEOUT_LIMIT);

  always_ff @(posedge clk) begin
    if (reset || !((state == S_ADDR) || (state == S_DATA)) || rx_ack)
      idle_cnt <= '0;
    else
      idle_cnt <= idle_cnt + 21'd1;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // The receiver clears its flag one cycle after the strobe, so that cycle is skipped.
  always_comb begin
    state_n  = state;
    rx_ack   = !reset && rx_state && rx_ready && !rx_ack_q;
    tx_start = !reset && (state == S_RESP) && tx_ready && !tx_start_q;
    case (state)
      S_IDLE: begin
        if (rx_ack) begin
          if ((rx_data == 8'h57) || (rx_data == 8'h52)) state_n = S_ADDR;
          else                                          state_n = S_RESP;
        end
      end
      S_ADDR: begin
        if (rx_ack && (cnt == 2'd3)) state_n = is_write ? S_DATA : S_BUS;
`ifdef UART_BUS_MASTER_TIMEOUT_EN
        else if (timeout) state_n = S_IDLE;
`endif
      end
      S_DATA: begin
        if (rx_ack && (cnt == 2'd3)) state_n = S_BUS;
`ifdef UART_BUS_MASTER_TIMEOUT_EN
        else if (timeout) state_n = S_IDLE;
`endif
      end
      S_BUS: begin
        if (mem_ready) state_n = S_RESP;
      end
      S_RESP: begin
        if (tx_start && (resp_one || (cnt == 2'd3))) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // One byte counter serves frame parsing and response transmission; it restarts on every state change.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      is_write   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      resp_q     <= '0;
      resp_one   <= 1'b0;
      rx_ack_q   <= 1'b0;
      tx_start_q <= 1'b0;
      tx_hold    <= '0;
    end else begin
      rx_ack_q   <= rx_ack;
      tx_start_q <= tx_start;

      if (state_n != state)         cnt <= '0;
      else if (rx_ack || tx_start)  cnt <= cnt + 2'd1;

      if ((state == S_IDLE) && rx_ack) begin
        is_write <= (rx_data == 8'h57);
        resp_q   <= 32'h0000_0015;
        resp_one <= 1'b1;
      end

      if ((state == S_ADDR) && rx_ack) begin
        case (cnt)
          2'd0:    addr_q[7:2]   <= rx_data[7:2];
          2'd1:    addr_q[15:8]  <= rx_data;
          2'd2:    addr_q[23:16] <= rx_data;
          default: addr_q[31:24] <= rx_data;
        endcase
      end

      if ((state == S_DATA) && rx_ack) wdata_q[{cnt, 3'b000} +: 8] <= rx_data;

      if ((state == S_BUS) && mem_ready) begin
        resp_q   <= is_write ? 32'h0000_0006 : mem_rdata;
        resp_one <= is_write;
      end

      if (tx_start) tx_hold <= tx_byte;
    end
  end

  assign tx_data   = tx_start ? tx_byte : tx_hold;
  assign busy      = (state != S_IDLE);
  assign mem_valid = (state == S_BUS);
  assign mem_addr  = {addr_q, 2'b00};
  assign mem_wdata = wdata_q;
  assign mem_wstrb = ((state == S_BUS) && is_write) ? 4'hF : 4'h0;

endmodule

// File: tb/tb_uart_bus_master.sv
// Directed bench for uart_bus_master with byte-stream receiver/transmitter models and a small word memory.
module tb_uart_bus_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_ready = 1'b0;
  logic        rx_ack;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_ready = 1'b1;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ready = 1'b0;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  rx_q[$];
  logic [7:0]  tx_q[$];
  bit          tx_stall = 1'b0;
  bit          ready_always = 1'b1;
  int          ready_at = 1;
  bit          rdata_force = 1'b0;
  logic [31:0] rdata_val = '0;
  logic [31:0] mem_arr[0:63];
  int          n_txn = 0;
  int          n_done = 0;
  int          vcnt = 0;
  int          last_len = 0;
  logic [31:0] cap_addr = '0;
  logic [31:0] cap_wdata = '0;
  logic [3:0]  cap_wstrb = '0;

  assign mem_rdata = rdata_force ? rdata_val : mem_arr[mem_addr[7:2]];

  always #5 clk = ~clk;

  uart_bus_master #(.TIMEOUT_CYCLES(100)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .rx_ack    (rx_ack),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .tx_ready  (tx_ready),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Receiver: presents queued bytes, drops its flag for the cycle after each strobe.
  initial begin
    bit ack_seen;
    forever begin
      @(negedge clk);
      ack_seen = rx_ack;
      @(posedge clk);
      #1;
      if (ack_seen) begin
        void'(rx_q.pop_front());
        rx_ready = 1'b0;
      end else if (!rx_ready && (rx_q.size() > 0)) begin
        rx_data  = rx_q[0];
        rx_ready = 1'b1;
      end
    end
  end

  // Transmitter: records each started byte and stays busy for a few cycles.
  initial begin
    bit         st;
    logic [7:0] d;
    int         hold;
    hold = 0;
    forever begin
      @(negedge clk);
      st = tx_start;
      d  = tx_data;
      if (st) check("tx_start_ready", 32'(tx_ready), 32'd1);
      @(posedge clk);
      #1;
      if (st) begin
        tx_q.push_back(d);
        tx_ready = 1'b0;
        hold = 4;
      end else if (hold > 0) begin
        hold--;
      end else begin
        tx_ready = !tx_stall;
      end
    end
  end

  // Memory: completes on sampled ready, counts distinct valid assertions and their length.
  initial begin
    forever begin
      @(negedge clk);
      if (mem_valid && mem_ready) begin
        n_done++;
        if (mem_wstrb == 4'hF) mem_arr[mem_addr[7:2]] = mem_wdata;
      end
      @(posedge clk);
      #1;
      if (mem_valid) begin
        vcnt++;
        if (vcnt == 1) begin
          n_txn++;
          cap_addr  = mem_addr;
          cap_wdata = mem_wdata;
          cap_wstrb = mem_wstrb;
        end else begin
          check("mem_addr_stable", mem_addr, cap_addr);
        end
      end else begin
        if (vcnt != 0) last_len = vcnt;
        vcnt = 0;
      end
      mem_ready = ready_always || (mem_valid && (vcnt == ready_at));
    end
  end

  task automatic frame(input logic [7:0] cmd, input logic [31:0] a, input logic [31:0] d,
                       input bit wr);
    rx_q.push_back(cmd);
    for (int k = 0; k < 4; k++) rx_q.push_back(a[8*k +: 8]);
    if (wr) for (int k = 0; k < 4; k++) rx_q.push_back(d[8*k +: 8]);
  endtask

  task automatic expect_tx(input string tag, input logic [31:0] exp, input int n);
    int i;
    i = 0;
    while ((tx_q.size() < n) && (i < 400)) begin
      @(posedge clk);
      i++;
    end
    #1;
    check({tag, "_count"}, 32'(tx_q.size()), 32'(n));
    for (int k = 0; k < n; k++)
      if (k < tx_q.size()) check(tag, {24'd0, tx_q[k]}, {24'd0, exp[8*k +: 8]});
    tx_q.delete();
  endtask

  task automatic wait_idle(input string tag);
    int i;
    i = 0;
    while ((busy || (rx_q.size() > 0) || !tx_ready) && (i < 400)) begin
      @(posedge clk);
      #1;
      i++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    int n0;
    int d0;
    int i;
    for (int k = 0; k < 64; k++) mem_arr[k] = 32'hA500_0000 | 32'(k);

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mem_valid", 32'(mem_valid), 32'd0);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_rx_ack", 32'(rx_ack), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    reset = 1'b0;

    // Write 0xDEADBEEF to 0x100; mem_ready is already high before the request
    n0 = n_txn;
    frame(8'h57, 32'h0000_0100, 32'hDEAD_BEEF, 1'b1);
    expect_tx("wr_ack", 32'h0000_0006, 1);
    check("wr_txn", 32'(n_txn - n0), 32'd1);
    check("wr_addr", cap_addr, 32'h0000_0100);
    check("wr_wdata", cap_wdata, 32'hDEAD_BEEF);
    check("wr_wstrb", 32'(cap_wstrb), 32'hF);
    check("wr_len", 32'(last_len), 32'd1);
    wait_idle("wr_idle");

    n0 = n_txn;
    frame(8'h52, 32'h0000_0100, 32'd0, 1'b0);
    expect_tx("rd_data", 32'hDEAD_BEEF, 4);
    check("rd_txn", 32'(n_txn - n0), 32'd1);
    check("rd_wstrb", 32'(cap_wstrb), 32'h0);
    check("rd_addr", cap_addr, 32'h0000_0100);
    wait_idle("rd_idle");

    n0 = n_txn;
    rx_q.push_back(8'h41);
    expect_tx("nak", 32'h0000_0015, 1);
    wait_idle("nak_idle");
    check("nak_no_txn", 32'(n_txn - n0), 32'd0);
    frame(8'h52, 32'h0000_0004, 32'd0, 1'b0);
    expect_tx("rd_after_nak", 32'hA500_0001, 4);
    check("rd_after_nak_txn", 32'(n_txn - n0), 32'd1);
    wait_idle("rd_after_nak_idle");

    // Delayed completion; low address bits from the host are dropped
    n0 = n_txn;
    ready_always = 1'b0;
    ready_at     = 6;
    rdata_force  = 1'b1;
    rdata_val    = 32'h1234_5678;
    frame(8'h52, 32'h0000_0103, 32'd0, 1'b0);
    expect_tx("rd_slow", 32'h1234_5678, 4);
    check("rd_slow_addr", cap_addr, 32'h0000_0100);
    check("rd_slow_len", 32'(last_len), 32'd6);
    check("rd_slow_txn", 32'(n_txn - n0), 32'd1);
    wait_idle("rd_slow_idle");
    rdata_force = 1'b0;

    // Reset while the bus request is outstanding
    ready_at = 1000;
    d0 = n_done;
    frame(8'h57, 32'h0000_0020, 32'h0000_0055, 1'b1);
    i = 0;
    while (!mem_valid && (i < 200)) begin
      @(posedge clk);
      #1;
      i++;
    end
    check("bus_reached", 32'(mem_valid), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_bus_valid", 32'(mem_valid), 32'd0);
    check("rst_bus_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("rst_bus_no_tx", 32'(tx_q.size()), 32'd0);
    check("rst_bus_no_done", 32'(n_done - d0), 32'd0);
    ready_always = 1'b1;

    // Transmitter held busy: response waits
    n0 = n_txn;
    tx_stall = 1'b1;
    frame(8'h57, 32'h0000_0040, 32'hCAFE_F00D, 1'b1);
    repeat (60) @(posedge clk);
    #1;
    check("stall_busy", 32'(busy), 32'd1);
    check("stall_no_tx", 32'(tx_q.size()), 32'd0);
    check("stall_tx_start", 32'(tx_start), 32'd0);
    check("stall_txn", 32'(n_txn - n0), 32'd1);
    tx_stall = 1'b0;
    expect_tx("stall_ack", 32'h0000_0006, 1);
    wait_idle("stall_idle");

    // Partial frame then silence
    n0 = n_txn;
    rx_q.push_back(8'h57);
    rx_q.push_back(8'h00);
    i = 0;
    while ((rx_q.size() > 0) && (i < 50)) begin
      @(posedge clk);
      #1;
      i++;
    end
    repeat (90) @(posedge clk);
    #1;
    check("partial_busy_early", 32'(busy), 32'd1);
    repeat (30) @(posedge clk);
    #1;
`ifdef UART_BUS_MASTER_TIMEOUT_EN
    check("timeout_busy", 32'(busy), 32'd0);
`else
    check("no_timeout_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
`endif
    check("partial_no_txn", 32'(n_txn - n0), 32'd0);
    check("partial_no_tx", 32'(tx_q.size()), 32'd0);
    frame(8'h57, 32'h0000_0008, 32'h4433_2211, 1'b1);
    expect_tx("post_partial_ack", 32'h0000_0006, 1);
    check("post_partial_txn", 32'(n_txn - n0), 32'd1);
    check("post_partial_addr", cap_addr, 32'h0000_0008);
    check("post_partial_wdata", cap_wdata, 32'h4433_2211);
    wait_idle("post_partial_idle");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
